// File: rtl/conv11_host_drv.sv
// Host-side driver for a conv11 unit: streams preloaded activation/weight buffers over
// valid/ready channels, sequences start/done, and captures results in a readable buffer.
module conv11_host_drv #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             host_start,
  output logic                                             host_done,
  output logic                                             busy,
  output logic                                             timeout_err,
  input  logic                                             wr_en,
  input  logic                                             wr_sel,
  input  logic [((NUM_IN > 1) ? $clog2(NUM_IN) : 1)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]                            wr_din,
  input  logic [((NUM_OUT > 1) ? $clog2(NUM_OUT) : 1)-1:0] rd_addr,
  output logic [OUT_WIDTH-1:0]                             rd_dout,
  output logic                                             conv_start,
  input  logic                                             conv_done,
  output logic                                             input_valid_out,
  input  logic                                             input_ready_in,
  output logic [DATA_WIDTH-1:0]                            data_out,
  output logic                                             weight_valid_out,
  input  logic                                             weight_ready_in,
  output logic [DATA_WIDTH-1:0]                            weight_data,
  input  logic                                             out_valid_in,
  output logic                                             out_ready_out,
  input  logic [OUT_WIDTH-1:0]                             out_data_in
);

  localparam int IN_AW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int OUT_AW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int IN_CW  = $clog2(NUM_IN + 1);
  localparam int OUT_CW = $clog2(NUM_OUT + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  localparam logic [IN_CW-1:0]  IN_MAX  = IN_CW'(NUM_IN);
  localparam logic [OUT_CW-1:0] OUT_MAX = OUT_CW'(NUM_OUT);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [IN_CW-1:0]      in_cnt_reg, w_cnt_reg;
  logic [OUT_CW-1:0]     o_cnt_reg;
  logic [WD_W-1:0]       wd_cnt_reg;
  logic                  done_latch_reg;
  logic                  timeout_err_reg;
  logic [OUT_WIDTH-1:0]  rd_dout_reg;

  logic [DATA_WIDTH-1:0] act_buf    [NUM_IN];
  logic [DATA_WIDTH-1:0] weight_buf [NUM_IN];
  logic [OUT_WIDTH-1:0]  res_buf    [NUM_OUT];

  logic run, in_hs, w_hs, out_hs, all_done, wd_expire;

  assign run       = (state_reg == S_RUN);
  assign in_hs     = input_valid_out & input_ready_in;
  assign w_hs      = weight_valid_out & weight_ready_in;
  assign out_hs    = out_ready_out & out_valid_in;
  assign all_done  = (in_cnt_reg == IN_MAX) && (w_cnt_reg == IN_MAX) &&
                     (o_cnt_reg == OUT_MAX) && done_latch_reg;
  assign wd_expire = run && (wd_cnt_reg == WD_LAST);

  // Valids and ready depend only on state and counters, never on the peer's ready/valid.
  assign input_valid_out  = run && (in_cnt_reg < IN_MAX);
  assign weight_valid_out = run && (w_cnt_reg < IN_MAX);
  assign out_ready_out    = run && (o_cnt_reg < OUT_MAX);
  assign data_out         = input_valid_out  ? act_buf[in_cnt_reg[IN_AW-1:0]]   : '0;
  assign weight_data      = weight_valid_out ? weight_buf[w_cnt_reg[IN_AW-1:0]] : '0;

  assign conv_start  = (state_reg == S_START);
  assign busy        = (state_reg != S_IDLE);
  assign host_done   = (state_reg == S_FIN);
  assign timeout_err = timeout_err_reg;
  assign rd_dout     = rd_dout_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (host_start) state_next = S_START;
      S_START: state_next = S_RUN;
      S_RUN:   if (all_done || wd_expire) state_next = S_FIN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      in_cnt_reg      <= '0;
      w_cnt_reg       <= '0;
      o_cnt_reg       <= '0;
      wd_cnt_reg      <= '0;
      done_latch_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && host_start) begin
        in_cnt_reg      <= '0;
        w_cnt_reg       <= '0;
        o_cnt_reg       <= '0;
        wd_cnt_reg      <= '0;
        done_latch_reg  <= 1'b0;
        timeout_err_reg <= 1'b0;
      end
      if (run) begin
        if (in_hs)     in_cnt_reg     <= in_cnt_reg + IN_CW'(1);
        if (w_hs)      w_cnt_reg      <= w_cnt_reg + IN_CW'(1);
        if (out_hs)    o_cnt_reg      <= o_cnt_reg + OUT_CW'(1);
        if (conv_done) done_latch_reg <= 1'b1;
        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        // A job that completes on the watchdog's last cycle is not an abort.
        if (wd_expire && !all_done) timeout_err_reg <= 1'b1;
      end
    end
  end

  // Input buffers are frozen for the whole job, including FIN.
  always_ff @(posedge clk) begin
    if (wr_en && state_reg == S_IDLE) begin
      if (wr_sel) act_buf[wr_addr]    <= wr_din;
      else        weight_buf[wr_addr] <= wr_din;
    end
  end

  always_ff @(posedge clk) begin
    if (out_hs) res_buf[o_cnt_reg[OUT_AW-1:0]] <= out_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_dout_reg <= '0;
    else     rd_dout_reg <= res_buf[rd_addr];
  end

endmodule

// File: tb/tb_conv11_host_drv.sv
// Directed bench for conv11_host_drv: a conv11 stand-in drives the channels, a job-level
// model checks every output each cycle, and literal expectations pin the observed streams.
module tb_conv11_host_drv;
  localparam int DW = 8;
  localparam int OW = 8;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst, host_start, host_done, busy, timeout_err;
  logic          wr_en, wr_sel;
  logic [1:0]    wr_addr, rd_addr;
  logic [DW-1:0] wr_din, data_out, weight_data;
  logic [OW-1:0] rd_dout, out_data_in;
  logic          conv_start, conv_done;
  logic          input_valid_out, input_ready_in, weight_valid_out, weight_ready_in;
  logic          out_valid_in, out_ready_out;

  always #5 clk = ~clk;

  conv11_host_drv #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_IN(NI), .NUM_OUT(NO), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .host_start(host_start), .host_done(host_done), .busy(busy),
    .timeout_err(timeout_err), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_din(wr_din), .rd_addr(rd_addr), .rd_dout(rd_dout), .conv_start(conv_start),
    .conv_done(conv_done), .input_valid_out(input_valid_out), .input_ready_in(input_ready_in),
    .data_out(data_out), .weight_valid_out(weight_valid_out), .weight_ready_in(weight_ready_in),
    .weight_data(weight_data), .out_valid_in(out_valid_in), .out_ready_out(out_ready_out),
    .out_data_in(out_data_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // conv11 stand-in configuration
  logic [3:0] in_pat, w_pat;
  bit         out_en;
  int         res_delay, done_mode;

  // conv11 stand-in: ready patterns indexed by cycles since conv_start
  initial begin
    bit env_act;
    int rc, res_sent;
    bit done_sent;
    env_act = 0; rc = 0; res_sent = 0; done_sent = 0;
    input_ready_in = 0; weight_ready_in = 0; out_valid_in = 0; out_data_in = '0; conv_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        env_act = 0;
      end else begin
        if (out_valid_in && out_ready_out) res_sent++;
        if (host_done) env_act = 0;
        if (conv_start) begin
          env_act = 1; rc = 0; res_sent = 0; done_sent = 0;
        end else begin
          rc++;
        end
      end
      @(posedge clk);
      #1;
      if (env_act) begin
        input_ready_in  = in_pat[rc % 4];
        weight_ready_in = w_pat[rc % 4];
        out_valid_in    = out_en && (rc >= res_delay);
        out_data_in     = (res_sent < NO) ? OW'(10 + res_sent) : OW'(99);
        conv_done       = 0;
        if (!done_sent && ((done_mode == 0 && res_sent == NO) || (done_mode == 1 && rc == 1))) begin
          conv_done = 1;
          done_sent = 1;
        end
      end else begin
        input_ready_in = 0; weight_ready_in = 0; out_valid_in = 0; out_data_in = '0; conv_done = 0;
      end
    end
  end

  // Job-level model and per-cycle compare
  logic [DW-1:0] act_m [NI];
  logic [DW-1:0] w_m   [NI];
  logic [OW-1:0] res_m [NO];
  logic [DW-1:0] sent_act[$];
  logic [DW-1:0] sent_w[$];
  int            done_cnt = 0;

  initial begin
    bit m_active, m_fin, m_terr, m_dl, run, exp_iv, exp_wv, exp_or, complete;
    int m_age, m_in, m_w, m_o, m_run;
    m_active = 0; m_fin = 0; m_terr = 0; m_dl = 0;
    m_age = 0; m_in = 0; m_w = 0; m_o = 0; m_run = 0;
    forever begin
      @(negedge clk);
      run    = m_active && (m_age >= 2) && !m_fin;
      exp_iv = run && (m_in < NI);
      exp_wv = run && (m_w < NI);
      exp_or = run && (m_o < NO);
      check("conv_start", conv_start, m_active && m_age == 1);
      check("busy", busy, m_active);
      check("host_done", host_done, m_fin);
      check("timeout_err", timeout_err, m_terr);
      check("input_valid", input_valid_out, exp_iv);
      check("weight_valid", weight_valid_out, exp_wv);
      check("out_ready", out_ready_out, exp_or);
      if (exp_iv && input_valid_out)  check("data_out", data_out, act_m[m_in]);
      if (exp_wv && weight_valid_out) check("weight_data", weight_data, w_m[m_w]);
      if (host_done) done_cnt++;

      if (rst) begin
        m_active = 0; m_fin = 0; m_terr = 0;
      end else begin
        if (!m_active && wr_en) begin
          if (wr_sel) act_m[wr_addr] = wr_din;
          else        w_m[wr_addr]   = wr_din;
        end
        if (m_fin) begin
          m_active = 0; m_fin = 0;
        end else if (m_active) begin
          if (run) begin
            complete = (m_in == NI) && (m_w == NI) && (m_o == NO) && m_dl;
            if (exp_iv && input_ready_in)  begin sent_act.push_back(data_out); m_in++; end
            if (exp_wv && weight_ready_in) begin sent_w.push_back(weight_data); m_w++; end
            if (exp_or && out_valid_in)    begin res_m[m_o] = out_data_in; m_o++; end
            if (conv_done) m_dl = 1;
            m_run++;
            if (complete) m_fin = 1;
            else if (m_run == TO) begin m_fin = 1; m_terr = 1; end
          end
          m_age++;
        end else if (host_start) begin
          m_active = 1; m_age = 1; m_in = 0; m_w = 0; m_o = 0; m_run = 0; m_dl = 0; m_terr = 0;
        end
      end
    end
  end

  task automatic write_word(input bit sel, input int addr, input int val);
    @(posedge clk); #1;
    wr_en = 1; wr_sel = sel; wr_addr = 2'(addr); wr_din = DW'(val);
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic start_job();
    sent_act.delete();
    sent_w.delete();
    @(posedge clk); #1;
    host_start = 1;
    @(posedge clk); #1;
    host_start = 0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    bit got;
    got = 0; cyc = 0;
    while (cyc < max_cyc && !got) begin
      @(negedge clk);
      cyc++;
      if (host_done) got = 1;
    end
    check("host_done_seen", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_sent();
    check("sent_act_count", sent_act.size(), NI);
    check("sent_w_count", sent_w.size(), NI);
    if (sent_act.size() == NI && sent_w.size() == NI) begin
      for (int i = 0; i < NI; i++) begin
        check("sent_act_word", sent_act[i], 1 + i);
        check("sent_w_word", sent_w[i], 5 + i);
      end
    end
  endtask

  task automatic check_results();
    for (int i = 0; i < NO; i++) begin
      @(posedge clk); #1;
      rd_addr = 2'(i);
      @(posedge clk);
      @(negedge clk);
      check("rd_dout", rd_dout, 10 + i);
    end
  endtask

  task automatic normal_cfg();
    in_pat = 4'hF; w_pat = 4'hF; out_en = 1; res_delay = 0; done_mode = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: got no finish, expected finish before 300000");
    $fatal(1, "time limit");
  end

  initial begin
    int cyc, d0;
    rst = 1; host_start = 0; wr_en = 0; wr_sel = 0; wr_addr = '0; wr_din = '0; rd_addr = '0;
    normal_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_host_done", host_done, 0);
    check("rst_conv_start", conv_start, 0);
    check("rst_in_valid", input_valid_out, 0);
    check("rst_w_valid", weight_valid_out, 0);
    check("rst_out_ready", out_ready_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_weight_data", weight_data, 0);
    check("rst_rd_dout", rd_dout, 0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < NI; i++) begin
      write_word(1'b1, i, 1 + i);
      write_word(1'b0, i, 5 + i);
    end

    // Job 1: everything always ready, done after the 4th result
    d0 = done_cnt;
    start_job();
    wait_done(100, cyc);
    check("job1_done_pulses", done_cnt - d0, 1);
    check_sent();
    check_results();

    // Job 2: stalled channels, input ready 1010 and weight ready 0011
    in_pat = 4'b0101; w_pat = 4'b1100;
    d0 = done_cnt;
    start_job();
    wait_done(100, cyc);
    check("job2_done_pulses", done_cnt - d0, 1);
    check_sent();
    normal_cfg();

    // Job 3: conv_done before the first result; host_start and wr_en during RUN
    done_mode = 1; res_delay = 3;
    start_job();
    @(posedge clk); #1;
    host_start = 1; wr_en = 1; wr_sel = 1; wr_addr = 2'd0; wr_din = DW'(77);
    @(posedge clk); #1;
    host_start = 0; wr_en = 0;
    wait_done(100, cyc);
    check_sent();
    check_results();
    normal_cfg();

    // Job 4: results never arrive, watchdog abort
    out_en = 0; done_mode = 2;
    start_job();
    wait_done(200, cyc);
    check("timeout_latency", cyc, 66);
    @(negedge clk);
    check("timeout_err_sticky", timeout_err, 1);
    normal_cfg();

    // Job 5: next start clears the abort flag; buffers unaffected by the ignored write
    start_job();
    @(negedge clk);
    check("timeout_err_cleared", timeout_err, 0);
    wait_done(100, cyc);
    check_sent();

    // Job 6: reset mid-RUN after two words
    d0 = done_cnt;
    start_job();
    cyc = 0;
    while (sent_act.size() < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("two_words_before_rst", sent_act.size() >= 2, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_in_valid", input_valid_out, 0);
    check("midrst_w_valid", weight_valid_out, 0);
    check("midrst_out_ready", out_ready_out, 0);
    check("midrst_conv_start", conv_start, 0);
    repeat (5) @(posedge clk);
    check("midrst_no_done", done_cnt - d0, 0);

    // Job 7: clean run after the mid-job reset
    #1;
    d0 = done_cnt;
    start_job();
    wait_done(100, cyc);
    check("job7_done_pulses", done_cnt - d0, 1);
    check_sent();
    check_results();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
